// File: rtl/motor_ramp_driver_pkg.sv
// -----------------------------------------------------------------------------
// motor_ramp_driver_pkg
// Shared definitions for the per-motor H-bridge output stage: default
// parameter values, FSM state encoding, the hb_out bit layout and a small
// counter-width helper.
// -----------------------------------------------------------------------------
package motor_ramp_driver_pkg;

   // Default configuration values used when the slave does not override them.
   localparam int DUTY_CYCLE_SIZE      = 8;
   localparam int PWM_PRESCALE         = 4;
   localparam int DEF_RAMP_STEP        = 1;
   localparam int DEF_DEADTIME_PERIODS = 4;

   typedef enum logic [1:0] {
      MRD_IDLE = 2'd0,
      MRD_RUN  = 2'd1,
      MRD_DEAD = 2'd2
   } mrd_state_t;

   // Bit layout of hb_out: [3]=busy, [2]=PWM enable, [1]=IN2, [0]=IN1.
   typedef struct packed {
      logic busy;
      logic pwm_en;
      logic in2;
      logic in1;
   } hb_bits_t;

   // Width of a counter that must hold values 0..max_val (never below 1 bit).
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w > 1) ? w : 1;
   endfunction

endpackage

// File: rtl/motor_ramp_driver_timebase.sv
// -----------------------------------------------------------------------------
// pwm_timebase
// Prescaler plus PWM period counter. The prescaler divides clk down to PWM
// ticks; pwm_cnt advances once per tick and wraps every 2^DUTY_W ticks.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   tick      out  high on the last clk of each prescaler cycle
//   boundary  out  tick on the last count of a PWM period
//   pwm_cnt   out  current position inside the PWM period
// -----------------------------------------------------------------------------
module pwm_timebase
   import motor_ramp_driver_pkg::*;
#(
   parameter int DUTY_W   = DUTY_CYCLE_SIZE,
   parameter int PRESCALE = PWM_PRESCALE
) (
   input  logic              clk,
   input  logic              reset,
   output logic              tick,
   output logic              boundary,
   output logic [DUTY_W-1:0] pwm_cnt
);

   localparam int               PRE_W   = cnt_width(PRESCALE - 1);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] prescaler;

   always_comb begin
      tick     = (prescaler == PRE_MAX);
      boundary = tick && (pwm_cnt == '1);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // in the design updates from values sampled before the same clock edge.
      if (reset) begin
         prescaler <= '0;
         pwm_cnt   <= '0;
      end else if (tick) begin
         prescaler <= '0;
         pwm_cnt   <= pwm_cnt + DUTY_W'(1);
      end else begin
         prescaler <= prescaler + PRE_W'(1);
      end
   end

endmodule

// File: rtl/motor_ramp_driver.sv
// -----------------------------------------------------------------------------
// motor_ramp_driver
// Output stage for one motor. Turns the on/dir/duty register fields into the
// 4-bit H-bridge GPIO group, with a period-aligned glitch-free PWM, a
// slew-limited duty ramp and a coast dead-time before any direction reversal.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   on            in   motor enable
//   dir           in   requested direction (0 = forward, 1 = reverse)
//   duty          in   requested duty cycle
//   hb_out        out  [0]=IN1, [1]=IN2, [2]=PWM enable, [3]=busy
//   duty_applied  out  duty currently being generated
//   period_start  out  one-clk pulse on the first clk of each PWM period
// -----------------------------------------------------------------------------
module motor_ramp_driver
   import motor_ramp_driver_pkg::*;
#(
   parameter int DUTY_W           = DUTY_CYCLE_SIZE,
   parameter int PRESCALE         = PWM_PRESCALE,
   parameter int RAMP_STEP        = DEF_RAMP_STEP,
   parameter int DEADTIME_PERIODS = DEF_DEADTIME_PERIODS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              on,
   input  logic              dir,
   input  logic [DUTY_W-1:0] duty,
   output logic [3:0]        hb_out,
   output logic [DUTY_W-1:0] duty_applied,
   output logic              period_start
);

   localparam int              DEAD_W   = cnt_width(DEADTIME_PERIODS - 1);
   localparam logic [DUTY_W:0] STEP_X   = (DUTY_W + 1)'(RAMP_STEP);
   localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEADTIME_PERIODS - 1);

   mrd_state_t        state, state_nxt;
   logic              cur_dir, cur_dir_nxt;
   logic [DUTY_W-1:0] applied_nxt;
   logic [DUTY_W-1:0] target, target_nxt;
   logic [DEAD_W-1:0] dead_cnt, dead_cnt_nxt;
   hb_bits_t          hb_q, hb_nxt;

   logic              tick_unused;
   logic              boundary;
   logic [DUTY_W-1:0] pwm_cnt;

   logic [DUTY_W-1:0] live_target;
   logic [DUTY_W:0]   ramp_up, ramp_dn;
   logic [DUTY_W-1:0] ramped;
   logic [DUTY_W-1:0] start_duty;

   // The tick output serves other consumers of the timebase; this stage only
   // acts on period boundaries.
   pwm_timebase #(
      .DUTY_W   (DUTY_W),
      .PRESCALE (PRESCALE)
   ) u_timebase (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick_unused),
      .boundary (boundary),
      .pwm_cnt  (pwm_cnt)
   );

   // Ramp arithmetic runs one bit wider so the step can never wrap; results
   // are clamped to the target so a ramp never overshoots.
   always_comb begin
      live_target = (on && (dir == cur_dir)) ? duty : '0;
      ramp_up     = {1'b0, duty_applied} + STEP_X;
      ramp_dn     = {1'b0, duty_applied} - STEP_X;
      if (duty_applied < live_target) begin
         ramped = (ramp_up > {1'b0, live_target}) ? live_target
                                                   : ramp_up[DUTY_W-1:0];
      end else begin
         // ramp_dn[DUTY_W] set means the subtraction borrowed past zero.
         ramped = (ramp_dn[DUTY_W] || (ramp_dn[DUTY_W-1:0] < live_target))
                  ? live_target : ramp_dn[DUTY_W-1:0];
      end
      start_duty = (STEP_X > {1'b0, duty}) ? duty : STEP_X[DUTY_W-1:0];
   end

   // Next-state logic: every decision is taken at a period boundary only, so
   // the PWM width never changes in the middle of a period.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the
      // branches below leaves it unassigned and infers a latch.
      state_nxt    = state;
      cur_dir_nxt  = cur_dir;
      applied_nxt  = duty_applied;
      target_nxt   = target;
      dead_cnt_nxt = dead_cnt;

      if (boundary) begin
         unique case (state)
            MRD_IDLE: begin
               if (on && (duty != '0)) begin
                  state_nxt   = MRD_RUN;
                  cur_dir_nxt = dir;
                  applied_nxt = start_duty;
                  target_nxt  = duty;
               end
            end
            MRD_RUN: begin
               if ((duty_applied == '0) && (live_target == '0)) begin
                  state_nxt    = MRD_DEAD;
                  dead_cnt_nxt = DEAD_LOAD;
                  target_nxt   = '0;
               end else begin
                  applied_nxt = ramped;
                  target_nxt  = live_target;
               end
            end
            MRD_DEAD: begin
               if (dead_cnt == '0) begin
                  state_nxt = MRD_IDLE;
               end else begin
                  dead_cnt_nxt = dead_cnt - DEAD_W'(1);
               end
            end
            default: state_nxt = MRD_IDLE;
         endcase
      end
   end

   // Bridge outputs derive from the current state and are registered, so they
   // trail the state register by one clk. IN1/IN2 are decoded from a single
   // cur_dir bit and therefore can never be high together.
   always_comb begin
      hb_nxt.in1    = (state == MRD_RUN) && cur_dir;
      hb_nxt.in2    = (state == MRD_RUN) && !cur_dir;
      hb_nxt.pwm_en = (state == MRD_RUN) && (pwm_cnt < duty_applied);
      hb_nxt.busy   = (state == MRD_DEAD) ||
                      ((state == MRD_RUN) && (duty_applied != target));
   end

   // Reset forces coast at once; any pending dead-time is abandoned.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= MRD_IDLE;
         cur_dir      <= 1'b0;
         duty_applied <= '0;
         target       <= '0;
         dead_cnt     <= '0;
         hb_q         <= '0;
         period_start <= 1'b0;
      end else begin
         state        <= state_nxt;
         cur_dir      <= cur_dir_nxt;
         duty_applied <= applied_nxt;
         target       <= target_nxt;
         dead_cnt     <= dead_cnt_nxt;
         hb_q         <= hb_nxt;
         period_start <= boundary;
      end
   end

   assign hb_out = hb_q;

endmodule

// File: tb/tb_motor_ramp_driver.sv
// -----------------------------------------------------------------------------
// tb_motor_ramp_driver
// Directed scenarios followed by randomized segments. A period-level reference
// model predicts hb_out, duty_applied and period_start on every clk.
// -----------------------------------------------------------------------------
module tb_motor_ramp_driver;

   localparam int DUTY_W   = 4;
   localparam int PRESCALE = 1;
   localparam int STEP     = 2;
   localparam int DEADTIME = 2;
   localparam int PERIOD   = (1 << DUTY_W) * PRESCALE;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DEAD = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              on;
   logic              dir;
   logic [DUTY_W-1:0] duty;
   logic [3:0]        hb_out;
   logic [DUTY_W-1:0] duty_applied;
   logic              period_start;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int         m_n;        // clks since reset release
   int         m_mode;
   int         m_applied;
   int         m_target;
   int         m_dir;
   int         m_dead_left; // DEAD periods still to spend
   logic [3:0] e_hb;
   logic       e_ps;

   always #5 clk = ~clk;

   motor_ramp_driver #(
      .DUTY_W           (DUTY_W),
      .PRESCALE         (PRESCALE),
      .RAMP_STEP        (STEP),
      .DEADTIME_PERIODS (DEADTIME)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .on           (on),
      .dir          (dir),
      .duty         (duty),
      .hb_out       (hb_out),
      .duty_applied (duty_applied),
      .period_start (period_start)
   );

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model across one clk edge given the inputs seen at that edge.
   task automatic model_edge(input bit rst, input bit on_v, input bit dir_v, input int duty_v);
      int pos;
      int tgt;
      bit run;
      if (rst) begin
         m_n = 0; m_mode = M_IDLE; m_applied = 0; m_target = 0;
         m_dir = 0; m_dead_left = 0; e_hb = 4'b0000; e_ps = 1'b0;
         return;
      end
      pos  = (m_n / PRESCALE) % (1 << DUTY_W);
      run  = (m_mode == M_RUN);
      e_hb = {(m_mode == M_DEAD) || (run && m_applied != m_target),
              run && (pos < m_applied),
              run && (m_dir == 0),
              run && (m_dir == 1)};
      e_ps = ((m_n % PERIOD) == PERIOD - 1);
      if (e_ps) begin
         if (m_mode == M_IDLE) begin
            if (on_v && duty_v != 0) begin
               m_mode = M_RUN; m_dir = dir_v;
               m_applied = imin(STEP, duty_v); m_target = duty_v;
            end
         end else if (m_mode == M_RUN) begin
            tgt = (on_v && dir_v == m_dir) ? duty_v : 0;
            if (m_applied == 0 && tgt == 0) begin
               m_mode = M_DEAD; m_dead_left = DEADTIME; m_target = 0;
            end else begin
               m_applied = (m_applied < tgt) ? imin(m_applied + STEP, tgt)
                                             : imax(m_applied - STEP, tgt);
               m_target = tgt;
            end
         end else begin
            m_dead_left--;
            if (m_dead_left == 0) m_mode = M_IDLE;
         end
      end
      m_n++;
   endtask

   task automatic step();
      bit r, o, d;
      int du;
      r = reset; o = on; d = dir; du = int'(duty);
      @(posedge clk);
      model_edge(r, o, d, du);
      #1;
      chk("hb_out", hb_out, e_hb);
      chk("duty_applied", duty_applied, m_applied);
      chk("period_start", period_start, e_ps);
      chk("in1_in2_excl", hb_out[0] & hb_out[1], 0);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_ps(output int waited);
      waited = 0;
      do begin
         step();
         waited++;
      end while (period_start !== 1'b1 && waited < 3 * PERIOD);
      chk("period_start_timeout", period_start, 1);
   endtask

   // Entered on a period_start clk; returns the applied duty of this period,
   // the number of PWM-high clks and a mid-period hb_out snapshot, and leaves
   // on the next period_start clk.
   task automatic run_period(output int highs, output int app, output logic [3:0] hb_mid);
      app    = int'(duty_applied);
      highs  = int'(hb_out[2]);
      hb_mid = 4'b0000;
      for (int i = 1; i < PERIOD; i++) begin
         step();
         highs += int'(hb_out[2]);
         if (i == PERIOD / 2) hb_mid = hb_out;
      end
      step();
   endtask

   initial begin
      int         h, a, w, ps_cnt;
      logic [3:0] m;
      int         s2_app [3]  = '{2, 4, 6};
      bit         s2_busy[3]  = '{1, 1, 0};
      int         s4_app [10] = '{6, 4, 2, 0, 0, 0, 0, 2, 4, 6};
      logic [3:0] s4_hb  [10] = '{4'b0010, 4'b1010, 4'b1010, 4'b0010, 4'b1000,
                                  4'b1000, 4'b0000, 4'b1001, 4'b1001, 4'b0001};

      reset = 1'b1; on = 1'b0; dir = 1'b0; duty = '0;

      // 1: reset then idle; period_start every PERIOD clks
      steps(3);
      reset = 1'b0;
      ps_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         ps_cnt += int'(period_start);
      end
      chk("idle_ps_count", ps_cnt, 6);
      chk("idle_hb", hb_out, 4'b0000);

      // 2: forward start and ramp to 6
      on = 1'b1; dir = 1'b0; duty = 4'd6;
      wait_ps(w);
      for (int i = 0; i < 3; i++) begin
         run_period(h, a, m);
         chk("s2_applied", a, s2_app[i]);
         chk("s2_width", h, s2_app[i]);
         chk("s2_dir", m[1:0], 2'b10);
         chk("s2_busy", m[3], s2_busy[i]);
      end

      // 3: mid-period duty change takes effect at the next boundary
      steps(5);
      duty = 4'd3;
      step();
      chk("s3_hold", duty_applied, 6);
      wait_ps(w);
      run_period(h, a, m);
      chk("s3_applied_a", a, 4); chk("s3_width_a", h, 4);
      run_period(h, a, m);
      chk("s3_applied_b", a, 3); chk("s3_width_b", h, 3);

      // 4: back to 6, then reverse through dead-time
      duty = 4'd6;
      run_period(h, a, m);
      run_period(h, a, m);
      chk("s4_pre", duty_applied, 6);
      dir = 1'b1;
      for (int i = 0; i < 10; i++) begin
         run_period(h, a, m);
         chk("s4_applied", a, s4_app[i]);
         chk("s4_width", h, s4_app[i]);
         chk("s4_hb_mid", m, s4_hb[i]);
      end

      // 5: stop, full-scale ramp with clamp, then stop again
      on = 1'b0;
      for (int i = 0; i < 7; i++) run_period(h, a, m);
      chk("s5_stopped_hb", m, 4'b0000);
      duty = 4'd15; dir = 1'b0; on = 1'b1;
      run_period(h, a, m);
      for (int k = 1; k <= 8; k++) begin
         run_period(h, a, m);
         chk("s5_up_applied", a, imin(2 * k, 15));
         chk("s5_up_width", h, imin(2 * k, 15));
      end
      on = 1'b0;
      for (int j = 0; j < 12; j++) begin
         run_period(h, a, m);
         if (j < 9) chk("s5_dn_applied", a, imax(15 - 2 * j, 0));
      end
      chk("s5_final_hb", hb_out, 4'b0000);
      chk("s5_final_applied", duty_applied, 0);

      // 6: reset in the middle of a run at applied=10
      on = 1'b1; duty = 4'd15; dir = 1'b0;
      for (int i = 0; i < 5; i++) run_period(h, a, m);
      chk("s6_pre_applied", duty_applied, 10);
      steps(6);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("s6_rst_hb", hb_out, 4'b0000);
      chk("s6_rst_applied", duty_applied, 0);
      duty = 4'd6;
      wait_ps(w);
      chk("s6_restart_latency", w, PERIOD);
      for (int i = 0; i < 3; i++) begin
         run_period(h, a, m);
         chk("s6_applied", a, s2_app[i]);
         chk("s6_width", h, s2_app[i]);
      end

      // Randomized segments, including occasional resets
      for (int seg = 0; seg < 40; seg++) begin
         on   = ($urandom_range(0, 3) != 0);
         dir  = 1'($urandom_range(0, 1));
         duty = DUTY_W'($urandom_range(0, (1 << DUTY_W) - 1));
         if ($urandom_range(0, 14) == 0) begin
            reset = 1'b1;
            steps($urandom_range(1, 2));
            reset = 1'b0;
         end
         steps($urandom_range(4, 80));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
